ifetch_queue: RTL and testbench

- Instruction-fetch front end; sits directly upstream of the main decoder and feeds it {instruction, PC} pairs.
- Generates sequential PCs, issues requests to instruction memory, and buffers in-order responses in a small FIFO.
- Supports redirects from execute (taken branch/jump) and halts fetch when decode raises pause (ECALL/EBREAK/FENCE) until resume.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/ifq_fifo.sv | 64 ++++++
 rtl/ifetch_queue.sv | 160 ++++++++++++++++
 tb/tb_ifetch_queue.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
package fetch_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_e;

   // Saturating 32-bit increment used by the statistics counters.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      logic [31:0] r;
      if (v == 32'hFFFF_FFFF) begin
         r = v;
      end else begin
         r = v + 32'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Generic synchronous FIFO with flush; power-of-two DEPTH, occupancy count.
// Storage is cleared by reset so the head reads zero after reset.
module ifq_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wptr_r;
   logic [AW-1:0]    rptr_r;
   logic [AW:0]      count_r;
   logic             full_s;
   logic             do_push_s;
   logic             do_pop_s;

   assign full_s    = (count_r == (AW+1)'(DEPTH));
   assign do_pop_s  = pop && (count_r != '0);
   // A push on a full FIFO is only taken when the head leaves the same cycle.
   assign do_push_s = push && (!full_s || do_pop_s);

   assign rdata = mem_r[rptr_r];
   assign count = count_r;

   // Storage, pointers and occupancy; flush empties the FIFO in one cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wptr_r  <= '0;
         rptr_r  <= '0;
         count_r <= '0;
      end else if (flush) begin
         wptr_r  <= '0;
         rptr_r  <= '0;
         count_r <= '0;
      end else begin
         if (do_push_s) begin
            mem_r[wptr_r] <= wdata;
            wptr_r        <= wptr_r + AW'(1'b1);
         end
         if (do_pop_s) begin
            rptr_r <= rptr_r + AW'(1'b1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + (AW+1)'(1'b1);
            2'b01:   count_r <= count_r - (AW+1)'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch queue: sequential PC generation, credit-limited memory
// requests, in-order response buffering toward decode, redirect and pause.
// Optional statistics outputs are enabled with the IFQ_STATS_EN macro.
module ifetch_queue #(
   parameter int               XLEN     = fetch_pkg::XLEN,
   parameter logic [XLEN-1:0]  RESET_PC = fetch_pkg::RESET_PC,
   parameter int               DEPTH    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [XLEN-1:0]  imem_req_addr,
   input  logic             imem_resp_valid,
   input  logic [XLEN-1:0]  imem_resp_data,
   output logic             dec_valid,
   input  logic             dec_ready,
   output logic [XLEN-1:0]  dec_instr,
   output logic [XLEN-1:0]  dec_pc,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_pc,
   input  logic             pause,
   input  logic             resume
`ifdef IFQ_STATS_EN
   ,
   output logic [31:0]      stat_fetched,
   output logic [31:0]      stat_dropped,
   output logic [31:0]      stat_stall
`endif
);

   import fetch_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_e    state_r;
   logic [XLEN-1:0] pc_r;
   logic [CW-1:0]   outstanding_r;
   logic [CW-1:0]   drop_r;

   logic [CW-1:0]     main_count_s;
   logic [CW-1:0]     side_count_s;
   logic [2*XLEN-1:0] main_rdata_s;
   logic [XLEN-1:0]   side_pc_s;
   logic [CW:0]       credit_used_s;
   logic              req_valid_s;
   logic              accept_s;
   logic              dropping_s;
   logic              push_s;
   logic              pop_s;
   logic [CW-1:0]     outstanding_nxt_s;

   // Entries already buffered plus requests in flight may never exceed DEPTH.
   assign credit_used_s  = {1'b0, main_count_s} + {1'b0, outstanding_r};
   assign req_valid_s    = rst_n && (state_r == RUN) && !redirect_valid &&
                           (credit_used_s < (CW+1)'(DEPTH));
   assign accept_s       = req_valid_s && imem_req_ready;
   assign dropping_s     = imem_resp_valid && (drop_r != '0);
   assign push_s         = imem_resp_valid && (drop_r == '0) && (side_count_s != '0);
   assign pop_s          = dec_valid && dec_ready;
   assign outstanding_nxt_s = outstanding_r + {{(CW-1){1'b0}}, accept_s}
                                            - {{(CW-1){1'b0}}, imem_resp_valid};

   assign imem_req_valid = req_valid_s;
   assign imem_req_addr  = pc_r;
   assign dec_valid      = (main_count_s != '0);
   assign dec_instr      = main_rdata_s[2*XLEN-1:XLEN];
   assign dec_pc         = main_rdata_s[XLEN-1:0];

   // PC of every accepted request, consumed when its response is kept.
   ifq_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_pc_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (accept_s),
      .pop   (push_s),
      .flush (redirect_valid),
      .wdata (pc_r),
      .rdata (side_pc_s),
      .count (side_count_s)
   );

   // {instruction, pc} pairs waiting for decode.
   ifq_fifo #(.DEPTH(DEPTH), .WIDTH(2*XLEN)) u_instr_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s),
      .pop   (pop_s),
      .flush (redirect_valid),
      .wdata ({imem_resp_data, side_pc_s}),
      .rdata (main_rdata_s),
      .count (main_count_s)
   );

   // Fetch PC, in-flight request count and pending-discard count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_r          <= RESET_PC;
         outstanding_r <= '0;
         drop_r        <= '0;
      end else begin
         outstanding_r <= outstanding_nxt_s;
         if (redirect_valid) begin
            // Everything still in flight belongs to the abandoned path.
            pc_r   <= redirect_pc & ~(XLEN'(32'd3));
            drop_r <= outstanding_nxt_s;
         end else begin
            if (accept_s) begin
               pc_r <= pc_r + XLEN'(32'd4);
            end else begin
               pc_r <= pc_r;
            end
            if (dropping_s) begin
               drop_r <= drop_r - CW'(1'b1);
            end else begin
               drop_r <= drop_r;
            end
         end
      end
   end

   // Run/halt control; redirect outranks pause, pause outranks resume.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= RUN;
      end else if (redirect_valid) begin
         state_r <= RUN;
      end else begin
         case (state_r)
            RUN: begin
               if (pause) state_r <= HALT;
               else       state_r <= RUN;
            end
            HALT: begin
               if (resume && !pause) state_r <= RUN;
               else                  state_r <= HALT;
            end
            default: state_r <= RUN;
         endcase
      end
   end

`ifdef IFQ_STATS_EN
   // Saturating event counters for kept responses, discards and decode stalls.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_fetched <= 32'd0;
         stat_dropped <= 32'd0;
         stat_stall   <= 32'd0;
      end else begin
         if (push_s && !redirect_valid) stat_fetched <= sat_inc32(stat_fetched);
         else                           stat_fetched <= stat_fetched;
         if (dropping_s) stat_dropped <= sat_inc32(stat_dropped);
         else            stat_dropped <= stat_dropped;
         if (dec_ready && !dec_valid && (state_r == RUN)) stat_stall <= sat_inc32(stat_stall);
         else                                             stat_stall <= stat_stall;
      end
   end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed scoreboard bench for ifetch_queue with a latency-configurable
// in-order instruction memory model.
module tb_ifetch_queue;

   import fetch_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        pause;
   logic        resume;
`ifdef IFQ_STATS_EN
   logic [31:0] stat_fetched;
   logic [31:0] stat_dropped;
   logic [31:0] stat_stall;
`endif

   always #5 clk = ~clk;

   ifetch_queue #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .dec_valid       (dec_valid),
      .dec_ready       (dec_ready),
      .dec_instr       (dec_instr),
      .dec_pc          (dec_pc),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .pause           (pause),
      .resume          (resume)
`ifdef IFQ_STATS_EN
      ,
      .stat_fetched    (stat_fetched),
      .stat_dropped    (stat_dropped),
      .stat_stall      (stat_stall)
`endif
   );

   typedef struct {
      int          due;
      logic [31:0] addr;
   } mreq_t;

   mreq_t       memq[$];
   logic [31:0] sb[$];
   logic [31:0] exp_pc;
   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          lat      = 1;
   int          accepts  = 0;
   int          pops     = 0;
`ifdef IFQ_STATS_EN
   int          drop_ctr    = 0;
   int          exp_fetched = 0;
   int          exp_dropped = 0;
`endif

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return NOP_INSTR ^ (a << 4);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n           = 1'b0;
      redirect_valid  = 1'b0;
      redirect_pc     = 32'h0;
      pause           = 1'b0;
      resume          = 1'b0;
      dec_ready       = 1'b1;
      imem_req_ready  = 1'b1;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      memq.delete();
      sb.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
      check("rst_dec_valid", {31'b0, dec_valid}, 32'h0);
      check("rst_dec_instr", dec_instr, 32'h0);
      check("rst_dec_pc", dec_pc, 32'h0);
      rst_n  = 1'b1;
      exp_pc = 32'h0000_0000;
      cyc    = 0;
`ifdef IFQ_STATS_EN
      drop_ctr    = 0;
      exp_fetched = 0;
      exp_dropped = 0;
`endif
   endtask

   // One clock: drive memory response, check outputs, advance models.
   task automatic cycle();
      logic acc;
      logic rsp;
      logic hs;
      rsp = 1'b0;
      imem_resp_data = 32'h0;
      if (memq.size() > 0) begin
         if (memq[0].due <= cyc) begin
            rsp = 1'b1;
            imem_resp_data = mem_word(memq[0].addr);
         end
      end
      imem_resp_valid = rsp;
      #1;
      acc = imem_req_valid && imem_req_ready;
      if (acc) check("req_addr", imem_req_addr, exp_pc);
      if (redirect_valid) check("req_in_redirect", {31'b0, imem_req_valid}, 32'h0);
      if (dec_valid) begin
         if (sb.size() == 0) begin
            check("dec_valid_stale", {31'b0, dec_valid}, 32'h0);
         end else begin
            check("dec_pc", dec_pc, sb[0]);
            check("dec_instr", dec_instr, mem_word(sb[0]));
         end
      end
      hs = dec_valid && dec_ready;
      @(posedge clk);
      if (hs && (sb.size() > 0)) begin
         void'(sb.pop_front());
         pops++;
      end
      if (rsp) begin
         void'(memq.pop_front());
`ifdef IFQ_STATS_EN
         if (drop_ctr > 0) begin
            exp_dropped++;
            drop_ctr--;
         end else if (!redirect_valid) begin
            exp_fetched++;
         end
`endif
      end
      if (acc) begin
         memq.push_back('{due: cyc + lat, addr: imem_req_addr});
         sb.push_back(exp_pc);
         exp_pc = exp_pc + 32'd4;
         accepts++;
      end
      if (redirect_valid) begin
         sb.delete();
         exp_pc = redirect_pc & ~32'd3;
`ifdef IFQ_STATS_EN
         drop_ctr = memq.size();
`endif
      end
      check("credit", ((sb.size() <= DEPTH) && (memq.size() <= DEPTH)) ? 32'd1 : 32'd0, 32'd1);
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      // Streaming: 1-cycle memory, decode always ready.
      do_reset();
      lat  = 1;
      pops = 0;
      repeat (12) cycle();
      check("s1_pops", pops, 32'd10);
`ifdef IFQ_STATS_EN
      check("s1_stat_stall", stat_stall, 32'd2);
      check("s1_stat_fetched", stat_fetched, exp_fetched);
`endif

      // Backpressure: decode stalled, credits cap requests at DEPTH.
      do_reset();
      dec_ready = 1'b0;
      accepts   = 0;
      repeat (10) cycle();
      check("s2_accepts", accepts, 32'd4);
      #1;
      check("s2_req_valid_off", {31'b0, imem_req_valid}, 32'h0);
      check("s2_head_pc", dec_pc, 32'h0);
      dec_ready = 1'b1;
      pops      = 0;
      repeat (4) cycle();
      check("s2_drain_pops", pops, 32'd4);

      // Redirect with two requests in flight on a 3-cycle memory.
      do_reset();
      lat = 3;
      repeat (2) cycle();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0100;
      cycle();
      redirect_valid = 1'b0;
      pops = 0;
      repeat (10) cycle();
      check("s3_pops_nonzero", (pops > 0) ? 32'd1 : 32'd0, 32'd1);
`ifdef IFQ_STATS_EN
      check("s3_stat_dropped", stat_dropped, 32'd2);
      check("s3_stat_dropped_model", stat_dropped, exp_dropped);
`endif

      // Pause at PC 0x20, in-flight work drains, resume continues sequentially.
      do_reset();
      lat = 2;
      for (int i = 0; i < 40 && exp_pc != 32'h20; i++) cycle();
      check("s4_reach_0x20", exp_pc, 32'h20);
      pause = 1'b1;
      cycle();
      pause   = 1'b0;
      accepts = 0;
      repeat (8) cycle();
      check("s4_no_req_halt", accepts, 32'd0);
      check("s4_drained", sb.size(), 32'd0);
      check("s4_dec_idle", {31'b0, dec_valid}, 32'h0);
      pause  = 1'b1;
      resume = 1'b1;
      cycle();
      pause  = 1'b0;
      resume = 1'b0;
      #1;
      check("s4_pause_beats_resume", {31'b0, imem_req_valid}, 32'h0);
      resume = 1'b1;
      cycle();
      resume  = 1'b0;
      accepts = 0;
      cycle();
      check("s4_resume_req", accepts, 32'd1);

      // Redirect and pause together from HALT: redirect wins, aligned target.
      pause = 1'b1;
      cycle();
      pause = 1'b0;
      cycle();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      pause          = 1'b1;
      cycle();
      redirect_valid = 1'b0;
      pause          = 1'b0;
      #1;
      check("s5_run_after_redirect", {31'b0, imem_req_valid}, 32'h1);
      check("s5_req_addr", imem_req_addr, 32'h0000_0100);
      accepts = 0;
      cycle();
      check("s5_accepts", accepts, 32'd1);

      // PC wrap from the top of the address space.
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      cycle();
      redirect_valid = 1'b0;
      accepts = 0;
      repeat (2) cycle();
      check("s6_accepts", accepts, 32'd2);
      check("s6_wrapped_next", exp_pc, 32'h0000_0004);
      pops = 0;
      repeat (8) cycle();
      check("s6_pops_nonzero", (pops > 1) ? 32'd1 : 32'd0, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
